// File: rtl/debug_dump_tx.sv
// debug_dump_tx
//   Transmit side of the debug link. Once the pipeline has halted, the
//   processor state is serialized into the UART transmitter as one
//   fixed-order frame, with every word sent MSB first:
//     PC, cycle count, reg[0..31], and optionally mem[0..2^NB_MEM-1].
//
//   Build option:
//     DEBUG_DUMP_MEM_EN - when defined, the data-memory section is sent
//                         (648-byte frame). When undefined, the frame ends
//                         after reg[31] (136 bytes) and the memory read
//                         port outputs are tied to 0.
//
//   Ports:
//     i_clock            system clock, rising edge
//     i_reset            asynchronous active-low reset
//     i_start            dump request, sampled only in IDLE
//     i_program_counter  PC, captured on start
//     i_cant_cycles      executed-cycle count, captured on start
//     i_reg_data         register bank read data (1-cycle synchronous read)
//     i_mem_data         data memory read data (1-cycle synchronous read)
//     i_tx_done          UART byte-sent pulse
//     o_addr_reg         register read address
//     o_ctrl_read_reg    register bank read enable / debug override
//     o_addr_mem         data memory read address
//     o_ctrl_read_mem    data memory debug read enable
//     o_tx_start         one-cycle UART start pulse
//     o_tx_data          byte to transmit, held until i_tx_done
//     o_busy             high while a frame is in progress
//     o_done             one-cycle pulse after the final byte
module debug_dump_tx #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_MEM  = 7
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_program_counter,
  input  logic [NB_DATA-1:0] i_cant_cycles,
  input  logic [NB_DATA-1:0] i_reg_data,
  input  logic [NB_DATA-1:0] i_mem_data,
  input  logic               i_tx_done,
  output logic [NB_REG-1:0]  o_addr_reg,
  output logic               o_ctrl_read_reg,
  output logic [NB_MEM-1:0]  o_addr_mem,
  output logic               o_ctrl_read_mem,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [3:0] {
    IDLE,
    SEND_PC,
    SEND_CYC,
    REQ_REG,
    WAIT_REG,
    SEND_REG,
`ifdef DEBUG_DUMP_MEM_EN
    REQ_MEM,
    WAIT_MEM,
    SEND_MEM,
`endif
    DONE
  } state_t;

  state_t              state;
  logic [NB_DATA-1:0]  cyc_q;
  logic [NB_DATA-1:0]  sh_q;      // remaining bytes of the current word, MSB aligned
  logic [1:0]          byte_cnt;
  logic [NB_REG-1:0]   reg_idx;
  logic                in_send;
  logic                tx_ack;
  logic                word_last;

`ifdef DEBUG_DUMP_MEM_EN
  logic [NB_MEM-1:0]   mem_idx;
  assign o_addr_mem = mem_idx;
`else
  logic                unused_mem;
  assign o_addr_mem      = '0;
  assign o_ctrl_read_mem = 1'b0;
  assign unused_mem      = ^i_mem_data;
`endif

  assign o_addr_reg = reg_idx;

  // A done pulse only counts once the start pulse has dropped, so a
  // done coincident with o_tx_start is ignored.
  always_comb begin
    in_send = 1'b0;
    case (state)
      SEND_PC, SEND_CYC, SEND_REG: in_send = 1'b1;
`ifdef DEBUG_DUMP_MEM_EN
      SEND_MEM:                    in_send = 1'b1;
`endif
      default:                     in_send = 1'b0;
    endcase
    tx_ack    = in_send && !o_tx_start && i_tx_done;
    word_last = (byte_cnt == 2'd3);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state           <= IDLE;
      cyc_q           <= '0;
      sh_q            <= '0;
      byte_cnt        <= '0;
      reg_idx         <= '0;
      o_ctrl_read_reg <= 1'b0;
`ifdef DEBUG_DUMP_MEM_EN
      mem_idx         <= '0;
      o_ctrl_read_mem <= 1'b0;
`endif
      o_tx_start      <= 1'b0;
      o_tx_data       <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;

      // Bytes 1..3 of a word come from the shift register in every SEND
      // state; the word-boundary action is state specific below.
      if (tx_ack) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (!word_last) begin
          o_tx_start <= 1'b1;
          o_tx_data  <= sh_q[NB_DATA-1 -: 8];
          sh_q       <= sh_q << 8;
        end
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            cyc_q      <= i_cant_cycles;
            sh_q       <= i_program_counter << 8;
            o_tx_data  <= i_program_counter[NB_DATA-1 -: 8];
            o_tx_start <= 1'b1;
            o_busy     <= 1'b1;
            byte_cnt   <= '0;
            reg_idx    <= '0;
`ifdef DEBUG_DUMP_MEM_EN
            mem_idx    <= '0;
`endif
            state      <= SEND_PC;
          end
        end

        SEND_PC: begin
          if (tx_ack && word_last) begin
            sh_q       <= cyc_q << 8;
            o_tx_data  <= cyc_q[NB_DATA-1 -: 8];
            o_tx_start <= 1'b1;
            state      <= SEND_CYC;
          end
        end

        SEND_CYC: begin
          if (tx_ack && word_last) begin
            o_ctrl_read_reg <= 1'b1;
            state           <= REQ_REG;
          end
        end

        REQ_REG: state <= WAIT_REG;

        WAIT_REG: begin
          sh_q       <= i_reg_data << 8;
          o_tx_data  <= i_reg_data[NB_DATA-1 -: 8];
          o_tx_start <= 1'b1;
          state      <= SEND_REG;
        end

        SEND_REG: begin
          if (tx_ack && word_last) begin
            if (reg_idx == '1) begin
              o_ctrl_read_reg <= 1'b0;
`ifdef DEBUG_DUMP_MEM_EN
              o_ctrl_read_mem <= 1'b1;
              state           <= REQ_MEM;
`else
              o_busy          <= 1'b0;
              o_done          <= 1'b1;
              state           <= DONE;
`endif
            end else begin
              reg_idx <= reg_idx + 1'b1;
              state   <= REQ_REG;
            end
          end
        end

`ifdef DEBUG_DUMP_MEM_EN
        REQ_MEM: state <= WAIT_MEM;

        WAIT_MEM: begin
          sh_q       <= i_mem_data << 8;
          o_tx_data  <= i_mem_data[NB_DATA-1 -: 8];
          o_tx_start <= 1'b1;
          state      <= SEND_MEM;
        end

        SEND_MEM: begin
          if (tx_ack && word_last) begin
            if (mem_idx == '1) begin
              o_ctrl_read_mem <= 1'b0;
              o_busy          <= 1'b0;
              o_done          <= 1'b1;
              state           <= DONE;
            end else begin
              mem_idx <= mem_idx + 1'b1;
              state   <= REQ_MEM;
            end
          end
        end
`endif

        // i_start is not looked at here; the next dump is taken from IDLE.
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Self-checking bench for debug_dump_tx. Stimulus pushes the expected
// frame into a scoreboard; a monitor pops one entry per o_tx_start and
// checks the byte, its timing relative to the triggering event, and the
// read address of the word being sent.
module tb_debug_dump_tx;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int NB_MEM  = 7;
`ifdef DEBUG_DUMP_MEM_EN
  localparam int FRAME_BYTES = 648;
`else
  localparam int FRAME_BYTES = 136;
`endif

  logic               i_clock = 1'b0;
  logic               i_reset = 1'b0;
  logic               i_start = 1'b0;
  logic [NB_DATA-1:0] pc_in   = '0;
  logic [NB_DATA-1:0] cyc_in  = '0;
  logic [NB_DATA-1:0] i_reg_data = '0;
  logic [NB_DATA-1:0] i_mem_data = '0;
  logic               model_done = 1'b0;
  logic               stim_done  = 1'b0;
  logic               i_tx_done;
  logic [NB_REG-1:0]  o_addr_reg;
  logic               o_ctrl_read_reg;
  logic [NB_MEM-1:0]  o_addr_mem;
  logic               o_ctrl_read_mem;
  logic               o_tx_start;
  logic [7:0]         o_tx_data;
  logic               o_busy;
  logic               o_done;

  assign i_tx_done = model_done | stim_done;

  debug_dump_tx #(
    .NB_DATA(NB_DATA),
    .NB_REG (NB_REG),
    .NB_MEM (NB_MEM)
  ) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_start          (i_start),
    .i_program_counter(pc_in),
    .i_cant_cycles    (cyc_in),
    .i_reg_data       (i_reg_data),
    .i_mem_data       (i_mem_data),
    .i_tx_done        (i_tx_done),
    .o_addr_reg       (o_addr_reg),
    .o_ctrl_read_reg  (o_ctrl_read_reg),
    .o_addr_mem       (o_addr_mem),
    .o_ctrl_read_mem  (o_ctrl_read_mem),
    .o_tx_start       (o_tx_start),
    .o_tx_data        (o_tx_data),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 i_clock = ~i_clock;

  // kind: 0 = no address check, 1 = register word, 2 = memory word
  typedef struct {
    logic [7:0]  data;
    int unsigned gap;
    bit          first;
    int unsigned kind;
    logic [7:0]  addr;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks   = 0;
  int          failures = 0;
  int unsigned edges = 0;
  int unsigned start_edge = 0;
  int unsigned last_done_edge = 0;
  int unsigned start_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned ans_cnt = 0;
  int unsigned ref_edge = 0;
  bit          glitch = 1'b0;
  bit          mem_rd_seen = 1'b0;
  bit          done_prev = 1'b0;

  always @(posedge i_clock) edges <= edges + 1;

  // register bank and data memory: 1-cycle synchronous reads
  always @(posedge i_clock) begin
    if (o_ctrl_read_reg) i_reg_data <= 32'h01010101 * {27'd0, o_addr_reg};
    if (o_ctrl_read_mem) i_mem_data <= 32'hA0000000 + {25'd0, o_addr_mem};
  end

  // UART model: answers each start 5 cycles later. With glitch set it also
  // raises a done in the start cycle, which must not be counted.
  always @(negedge i_clock) begin
    model_done = 1'b0;
    if (!i_reset) begin
      ans_cnt = 0;
    end else if (o_tx_start) begin
      ans_cnt = 5;
      if (glitch) model_done = 1'b1;
    end else if (ans_cnt != 0) begin
      ans_cnt--;
      if (ans_cnt == 0) begin
        model_done     = 1'b1;
        last_done_edge = edges + 1;
      end
    end
  end

  // monitor
  always @(negedge i_clock) begin
    if (o_ctrl_read_mem) mem_rd_seen = 1'b1;
    if (o_tx_start) begin
      start_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_start got data=%02h, scoreboard empty", o_tx_data);
      end else begin
        e = sb.pop_front();
        ref_edge = e.first ? start_edge : last_done_edge;
        if (o_tx_data !== e.data || (edges - ref_edge) != e.gap) begin
          failures++;
          $display("FAIL tx_byte #%0d got data=%02h gap=%0d expected data=%02h gap=%0d",
                   start_cnt, o_tx_data, edges - ref_edge, e.data, e.gap);
        end
        if (e.kind == 1) begin
          checks++;
          if (o_addr_reg !== e.addr[4:0] || o_ctrl_read_reg !== 1'b1) begin
            failures++;
            $display("FAIL reg_addr got addr=%0d rd=%b expected addr=%0d rd=1",
                     o_addr_reg, o_ctrl_read_reg, e.addr);
          end
        end
        if (e.kind == 2) begin
          checks++;
          if (o_addr_mem !== e.addr[6:0] || o_ctrl_read_mem !== 1'b1) begin
            failures++;
            $display("FAIL mem_addr got addr=%0d rd=%b expected addr=%0d rd=1",
                     o_addr_mem, o_ctrl_read_mem, e.addr);
          end
        end
      end
    end
    if (o_done) begin
      done_cnt++;
      checks++;
      if (done_prev || o_busy || sb.size() != 0 || o_ctrl_read_reg || o_ctrl_read_mem ||
          edges != last_done_edge) begin
        failures++;
        $display("FAIL done_pulse got prev=%b busy=%b left=%0d rdr=%b rdm=%b edge=%0d expected prev=0 busy=0 left=0 rdr=0 rdm=0 edge=%0d",
                 done_prev, o_busy, sb.size(), o_ctrl_read_reg, o_ctrl_read_mem, edges, last_done_edge);
      end
    end
    done_prev = o_done;
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input bit first, input int unsigned gap0,
                           input int unsigned kind, input logic [7:0] addr);
    exp_t x;
    for (int b = 0; b < 4; b++) begin
      x.data  = w[31-8*b -: 8];
      x.first = first && (b == 0);
      x.gap   = (b == 0) ? gap0 : 0;
      x.kind  = (b == 0) ? kind : 0;
      x.addr  = addr;
      sb.push_back(x);
    end
  endtask

  task automatic push_frame(input logic [31:0] pc, input logic [31:0] cyc);
    push_word(pc, 1'b1, 0, 0, 8'd0);
    push_word(cyc, 1'b0, 0, 0, 8'd0);
    for (int i = 0; i < 32; i++)
      push_word(32'h01010101 * i, 1'b0, 2, 1, 8'(i));
`ifdef DEBUG_DUMP_MEM_EN
    for (int a = 0; a < 128; a++)
      push_word(32'hA0000000 + a, 1'b0, 2, 2, 8'(a));
`endif
  endtask

  task automatic start_dump(input logic [31:0] pc, input logic [31:0] cyc);
    @(negedge i_clock);
    pc_in      = pc;
    cyc_in     = cyc;
    i_start    = 1'b1;
    start_edge = edges + 1;
    @(negedge i_clock);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned target, input string name);
    int unsigned n = 0;
    while (done_cnt < target && n < 20000) begin
      @(negedge i_clock);
      n++;
    end
    check(name, longint'(done_cnt >= target), 1);
  endtask

  task automatic wait_bytes(input int unsigned base, input int unsigned cnt, input string name);
    int unsigned n = 0;
    while (start_cnt - base < cnt && n < 5000) begin
      @(negedge i_clock);
      n++;
    end
    check(name, longint'(start_cnt - base >= cnt), 1);
  endtask

  int unsigned s0;
  int unsigned s1;

  initial begin
    // reset while idle, then release
    repeat (3) @(negedge i_clock);
    check("reset_outputs", {o_addr_reg, o_ctrl_read_reg, o_addr_mem, o_ctrl_read_mem,
                            o_tx_start, o_tx_data, o_busy, o_done}, 0);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);
    check("release_outputs", {o_addr_reg, o_ctrl_read_reg, o_addr_mem, o_ctrl_read_mem,
                              o_tx_start, o_tx_data, o_busy, o_done}, 0);
    stim_done = 1'b1;
    @(negedge i_clock);
    stim_done = 1'b0;
    repeat (10) @(negedge i_clock);
    check("idle_done_ignored", start_cnt, 0);

    // frame 1: PC=3, cycles=4
    s0 = start_cnt;
    push_frame(32'h00000003, 32'h00000004);
    start_dump(32'h00000003, 32'h00000004);
    wait_done(1, "frame1_done_timeout");
    check("frame1_bytes", start_cnt - s0, FRAME_BYTES);

    // frame 2: done coincident with each start, plus a second start mid-frame
    glitch = 1'b1;
    s0 = start_cnt;
    push_frame(32'h12345678, 32'hDEADBEEF);
    start_dump(32'h12345678, 32'hDEADBEEF);
    wait_bytes(s0, 20, "frame2_progress_timeout");
    @(negedge i_clock);
    pc_in   = 32'h55555555;
    i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    wait_done(2, "frame2_done_timeout");
    check("frame2_bytes", start_cnt - s0, FRAME_BYTES);
    glitch = 1'b0;

    // frame 3: reset asserted at byte 50
    s0 = start_cnt;
    push_frame(32'h0BADF00D, 32'h00C0FFEE);
    start_dump(32'h0BADF00D, 32'h00C0FFEE);
    wait_bytes(s0, 50, "frame3_progress_timeout");
    @(negedge i_clock);
    #2 i_reset = 1'b0;
    sb.delete();
    s1 = start_cnt;
    repeat (20) @(negedge i_clock);
    check("reset_quiet", start_cnt - s1, 0);
    check("midreset_outputs", {o_addr_reg, o_ctrl_read_reg, o_addr_mem, o_ctrl_read_mem,
                               o_tx_start, o_tx_data, o_busy, o_done}, 0);
    i_reset = 1'b1;
    repeat (3) @(negedge i_clock);

    // frame 4: fresh frame after reset restarts at PC[31:24]
    s0 = start_cnt;
    push_frame(32'hCAFE0001, 32'h00010203);
    start_dump(32'hCAFE0001, 32'h00010203);
    wait_done(3, "frame4_done_timeout");
    check("frame4_bytes", start_cnt - s0, FRAME_BYTES);
    repeat (5) @(negedge i_clock);
    check("idle_busy", o_busy, 0);

`ifdef DEBUG_DUMP_MEM_EN
    check("mem_read_seen", mem_rd_seen, 1);
`else
    check("mem_read_seen", mem_rd_seen, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_dump_tx.md
# debug_dump_tx

Transmit side of the debug link. After the pipeline halts, it reads the processor state and serializes it byte-by-byte into the UART transmitter as one fixed-order frame. The frame carries the program counter, the cycle count, all 32 bank registers and, optionally, data memory. It sits between the register bank / data memory read ports and the UART TX handshake, and is the counterpart of the program-loading receive path.

## Interface
Parameters:
- NB_DATA, 32, word width of the PC, the cycle count, registers and memory words
- NB_REG, 5, register address width (32 registers)
- NB_MEM, 7, data-memory address width (128 words)

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  dump request (halt seen); sampled only in IDLE
- i_program_counter  in  NB_DATA  PC value, captured on start
- i_cant_cycles  in  NB_DATA  executed-cycle count, captured on start
- i_reg_data  in  NB_DATA  register bank read data; 1-cycle synchronous read
- i_mem_data  in  NB_DATA  data memory read data; 1-cycle synchronous read
- i_tx_done  in  1  UART byte-sent pulse
- o_addr_reg  out  NB_REG  register read address
- o_ctrl_read_reg  out  1  register bank read enable / debug override
- o_addr_mem  out  NB_MEM  data memory read address
- o_ctrl_read_mem  out  1  data memory debug read enable
- o_tx_start  out  1  one-cycle UART start pulse
- o_tx_data  out  8  byte to transmit; stable from start until i_tx_done
- o_busy  out  1  high from the start-accept cycle through the last i_tx_done
- o_done  out  1  one-cycle pulse after the final byte

## Operation
- Frame order:
  - PC, then cycles, then reg[0..31], then mem[0..2^NB_MEM-1].
  - Each word is sent as 4 bytes, MSB first: [31:24], [23:16], [15:8], [7:0].
- Frame length: 648 bytes with memory, 136 bytes without.
- States:
  - IDLE: i_start=1 captures PC and cycles, then goes to SEND_PC.
  - SEND_PC: 4 bytes, then SEND_CYC.
  - SEND_CYC: 4 bytes, then REQ_REG.
  - REQ_REG: drives the register address, then WAIT_REG.
  - WAIT_REG: latches i_reg_data, then SEND_REG.
  - SEND_REG: 4 bytes, then REQ_REG with the next index, or, after index 31, REQ_MEM (or DONE when memory is compiled out).
  - REQ_MEM → WAIT_MEM → SEND_MEM: same pattern as registers, ending after the last address.
  - DONE: pulses o_done, returns to IDLE.
- Byte handshake:
  - o_tx_start is high for exactly one cycle with o_tx_data valid.
  - The FSM then waits for i_tx_done.
  - The byte counter is 2 bits; after byte 3 it advances to the next word.
- Index counters:
  - Register index is NB_REG bits; memory index is NB_MEM bits.
  - Terminal detection is on the all-ones value, so the counters never wrap into a second pass.
- o_ctrl_read_reg is high from REQ_REG until the last register byte; o_ctrl_read_mem is likewise high for the memory section; both are low otherwise.
- Boundary conditions:
  - i_start while busy: ignored.
  - i_tx_done outside a wait: ignored.
  - i_tx_done in the same cycle as o_tx_start: not counted. The wait begins the cycle after the start pulse.
  - i_start in the o_done cycle: ignored. A new dump is accepted from the next IDLE cycle.
  - Reset mid-frame: the frame is abandoned immediately, all outputs return to their reset values, and there is no resume.

## Timing
- Reset values: every output is 0, state is IDLE, and all counters and capture registers are 0.
- Start latency: with i_start sampled at edge N, o_tx_start is high in cycle N+1 carrying PC[31:24].
- Inside a word: i_tx_done at edge M produces the next o_tx_start in cycle M+1.
- Word fetch: after the last byte's i_tx_done, the FSM spends one REQ cycle and one WAIT cycle, so the next o_tx_start is in cycle M+3.
- o_done: high for the one cycle after the final i_tx_done. o_busy falls in that same cycle.

## Configuration
- DEBUG_DUMP_MEM_EN:
  - Defined: the memory section is sent; o_addr_mem and o_ctrl_read_mem are active; the frame is 648 bytes.
  - Undefined: REQ_MEM, WAIT_MEM and SEND_MEM are not built; o_addr_mem and o_ctrl_read_mem are tied to 0; the frame ends after reg[31] with 136 bytes.

## Test plan
- Reset low while idle, then release → all outputs 0. An i_tx_done pulse produces no o_tx_start.
- PC=0x00000003, cycles=0x00000004, i_start pulse, UART model answering each start 5 cycles later → first 8 bytes are 00 00 00 03 00 00 00 04, and the first byte starts one cycle after start.
- Register model reg[i]=i×0x01010101 → bytes 9–136 match, and o_addr_reg steps 0..31 with a two-cycle gap before each word.
- With DEBUG_DUMP_MEM_EN and mem[a]=0xA0000000+a → 648 bytes total, ending A0 00 00 7F, then o_done for one cycle with o_busy low. Without the macro → 136 bytes, o_ctrl_read_mem never high.
- Second i_start mid-frame → ignored, byte count unchanged. Reset asserted at byte 50 → o_tx_start stops, and a new start after release restarts from PC[31:24].
